// File: rtl/bus_fifo_param.sv
// bus_fifo_param: parametrised single-clock FIFO with normal or show-ahead read,
// fill level, almost flags and sticky overflow/underflow flags; all outputs registered.
module bus_fifo_param #(
  parameter int W         = 32,
  parameter int N         = 128,
  parameter bit SHOWAHEAD = 1'b0,
  parameter int AF_THR    = N - 4,
  parameter int AE_THR    = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 sclr_i,
  input  logic [W-1:0]         data_i,
  input  logic                 we_i,
  input  logic                 re_i,
  output logic [W-1:0]         data_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic                 almost_full_o,
  output logic                 almost_empty_o,
  output logic [$clog2(N):0]   level_o,
  output logic                 ovf_o,
  output logic                 udf_o
);
  localparam int AW = $clog2(N);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] NL = LW'(N);
  localparam logic [LW-1:0] AF = LW'(AF_THR);
  localparam logic [LW-1:0] AE = LW'(AE_THR);
  logic [W-1:0]  r_mem [N];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic          r_pf_valid;
  logic          w_wr_acc;
  logic          w_rd_acc;
  logic          w_load;
  logic          w_pf_nxt;
  logic [LW-1:0] w_ram_cnt;
  logic [LW-1:0] w_level_nxt;
  // In show-ahead mode the head word lives in data_o; w_ram_cnt counts words still only in RAM.
  always_comb begin
    w_wr_acc    = we_i && !full_o && !sclr_i;
    w_rd_acc    = re_i && !empty_o;
    w_ram_cnt   = level_o - LW'(r_pf_valid);
    w_load      = SHOWAHEAD ? ((!r_pf_valid || w_rd_acc) && w_ram_cnt != '0) : w_rd_acc;
    w_pf_nxt    = w_load || (r_pf_valid && !w_rd_acc);
    w_level_nxt = level_o + LW'(w_wr_acc) - LW'(w_rd_acc);
  end
  always_ff @(posedge clk_i)
    if (w_wr_acc) r_mem[r_wr_ptr] <= data_i;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_pf_valid     <= 1'b0;
      level_o        <= '0;
      data_o         <= '0;
      empty_o        <= 1'b1;
      full_o         <= 1'b0;
      almost_full_o  <= 1'b0;
      almost_empty_o <= 1'b1;
      ovf_o          <= 1'b0;
      udf_o          <= 1'b0;
    end else if (sclr_i) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_pf_valid     <= 1'b0;
      level_o        <= '0;
      data_o         <= '0;
      empty_o        <= 1'b1;
      full_o         <= 1'b0;
      almost_full_o  <= 1'b0;
      almost_empty_o <= 1'b1;
      ovf_o          <= 1'b0;
      udf_o          <= 1'b0;
    end else begin
      r_wr_ptr       <= r_wr_ptr + AW'(w_wr_acc);
      r_rd_ptr       <= r_rd_ptr + AW'(w_load);
      r_pf_valid     <= w_pf_nxt;
      level_o        <= w_level_nxt;
      if (w_load) data_o <= r_mem[r_rd_ptr];
      empty_o        <= SHOWAHEAD ? !w_pf_nxt : (w_level_nxt == '0);
      full_o         <= w_level_nxt == NL;
      almost_full_o  <= w_level_nxt >= AF;
      almost_empty_o <= w_level_nxt <= AE;
      ovf_o          <= ovf_o || (we_i && full_o);
      udf_o          <= udf_o || (re_i && empty_o);
    end
endmodule

// File: doc/bus_fifo_param.md
# bus_fifo_param

Parametrised synchronous FIFO for the bus output path, the next generation of the fixed 32×128 bus output FIFO. Adds configurable width and depth, a selectable normal or show-ahead read mode, a fill level, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags. Storage is inferred block RAM with no vendor FIFO primitive. It sits between bus-side producers and the readout/transmit logic and carries the same single clock domain.

## Interface
- W, 32: data width in bits.
- N, 128: depth in words; power of two, 4..4096.
- SHOWAHEAD, 0: 0 selects a normal read, where data follows re_i. 1 selects first-word fall-through.
- AF_THR, N-4: almost_full_o asserts when level_o >= AF_THR.
- AE_THR, 4: almost_empty_o asserts when level_o <= AE_THR.

- clk_i  in  1  clock; everything is sampled on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- sclr_i  in  1  synchronous clear. Same effect as reset, applied on a clock edge.
- data_i  in  W  write data.
- we_i  in  1  write request.
- re_i  in  1  read request (SHOWAHEAD=0) or pop of the head word (SHOWAHEAD=1).
- data_o  out  W  read data.
- empty_o  out  1  no readable word.
- full_o  out  1  level_o == N.
- almost_full_o  out  1  level_o >= AF_THR.
- almost_empty_o  out  1  level_o <= AE_THR.
- level_o  out  $clog2(N)+1  number of words stored, 0..N.
- ovf_o  out  1  sticky flag: a write arrived while full.
- udf_o  out  1  sticky flag: a read arrived while empty.

## Operation
- Pointers:
  - wr_ptr and rd_ptr are $clog2(N) bits wide and wrap naturally from N-1 to 0.
  - level_o is a separate counter; pointer equality is never used to tell full from empty.
- Write acceptance: a write is accepted when we_i=1 and full_o=0. The word goes to mem[wr_ptr] and wr_ptr increments.
- Read acceptance: a read is accepted when re_i=1 and empty_o=0. rd_ptr increments.
- Rejected requests:
  - A write while full is dropped. Memory, pointers and level are unchanged, and ovf_o is set.
  - A read while empty is ignored. data_o holds its value, and udf_o is set.
  - ovf_o and udf_o clear only on rst_i or sclr_i.
- Simultaneous accepted read and write: both pointers advance and level_o is unchanged.
  - When full, a write is still rejected even if a read is accepted in the same cycle.
  - When empty, the read is rejected and the write is accepted.
- Level update: level_o changes +1 on a write alone, −1 on a read alone, and 0 otherwise. It is never below 0 and never above N.
- SHOWAHEAD=0: data_o updates one cycle after an accepted read and holds at all other times.
- SHOWAHEAD=1:
  - An internal prefetch register holds the head word. data_o always equals the head word while empty_o=0.
  - An accepted pop presents the next word on data_o in the following cycle, with no bubble while level_o>1.
  - level_o includes the prefetched word.
- Reset and sclr_i:
  - level_o, both pointers, ovf_o and udf_o go to 0. empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=0, data_o=0.
  - Memory contents are not cleared.
  - sclr_i has priority over a write or read in the same cycle.
  - A reset in the middle of a burst discards all stored data.

## Timing
- Registered outputs: all flags, level_o and data_o come from registers. There is no combinational path from an input to an output.
- Write to flags:
  - A write accepted at edge k is visible in level_o, full_o and the almost flags after edge k.
  - SHOWAHEAD=0: empty_o deasserts after edge k.
  - SHOWAHEAD=1: empty_o deasserts after edge k+1, because of the RAM read and prefetch load. level_o still updates after edge k.
- Read to flags:
  - full_o deasserts after the edge at which the read is accepted.
  - empty_o asserts after the edge that takes level_o to 0.
- Throughput: one write and one read per cycle, sustained, in both modes.

## Test plan
- Reset and fill, W=32, N=8, SHOWAHEAD=0:
  - Reset, then write 0x00..0x07 on consecutive cycles → full_o=1 after the 8th edge, level_o=8, almost_full_o=1 from level 4.
  - A 9th write → ovf_o=1, level stays 8.
- Drain, normal mode: read 8 times → data_o=0x00..0x07, each one cycle after its re_i; empty_o=1 after the 8th read.
  - One further read → udf_o=1, data_o holds 0x07.
- Show-ahead, N=8: write 0xA5 to an empty FIFO → empty_o=0 two edges later with data_o=0xA5 and no read issued.
  - Write 0x5A, then pop → data_o=0x5A on the next cycle.
- Simultaneous traffic at level 3: we_i=re_i=1 for 20 cycles → level_o stays 3, data order preserved.
  - Pointers wrap past N-1 with no glitch on empty_o or full_o.
- Boundary cases: when full, assert we_i and re_i together → read accepted, write rejected, ovf_o=1, level_o=7.
  - When empty, assert both → write accepted, udf_o=1, level_o=1.
- Asynchronous reset mid-burst: assert rst_i between edges while level_o=5 → every output takes its reset value immediately.
  - Subsequent writes start at address 0. sclr_i gives the same result on the next edge.
